gcd_dispatcher: RTL

GCD_DISPATCHER -- requirements
Module: gcd_dispatcher

---
 rtl/gcd_pkg.sv | 7 +
 rtl/gcd_pair_fifo.sv | 41 ++++
 rtl/gcd_dispatcher.sv | 117 +++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// gcd_pkg: shared data width, FSM encoding and default sizing for the GCD dispatcher
package gcd_pkg;
  localparam int DATA_W = 8;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_TIMEOUT = 255;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
endpackage

// File: rtl/gcd_pair_fifo.sv
// gcd_pair_fifo: power-of-two circular buffer of operand pairs, push and pop may coincide even when full
module gcd_pair_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] fill;
  logic do_push, do_pop;
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full = fill == (AW+1)'(DEPTH);
  assign empty = fill == '0;
  assign dout = mem[rd_ptr];
  assign count = fill;
  // pointers and occupancy; a simultaneous push and pop leaves occupancy unchanged
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      fill <= fill + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  // storage needs no reset since only occupied slots are ever read
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/gcd_dispatcher.sv
// gcd_dispatcher: queues operand pairs and feeds them one at a time to an external GCD engine with timeout
module gcd_dispatcher
  import gcd_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              in_ready,
  output logic              gcd_start,
  output logic [DATA_W-1:0] gcd_a,
  output logic [DATA_W-1:0] gcd_b,
  input  logic              gcd_done,
  input  logic [DATA_W-1:0] gcd_y,
  input  logic              gcd_error,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_y,
  output logic              out_error,
  output logic              out_timeout,
  input  logic              out_ready
);
  localparam int FW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 2);
  state_t state, state_n;
  logic [TW-1:0] cnt, cnt_n;
  logic [FW-1:0] fill, fill_n;
  logic [2*DATA_W-1:0] head;
  logic push, pop, full, empty;
  logic ready_n, start_n, valid_n, err_n, to_n;
  logic [DATA_W-1:0] a_n, b_n, y_n;
  assign push = in_valid & in_ready & ~full;
  assign pop = (state == IDLE) & ~empty;
  assign fill_n = fill + FW'(push) - FW'(pop);
  assign ready_n = fill_n != FW'(DEPTH);
  gcd_pair_fifo #(.DEPTH(DEPTH), .W(2*DATA_W)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .din({in_a, in_b}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(fill)
  );
  // next state and next value of every registered output; the head is popped on the IDLE->ISSUE edge
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    start_n = 1'b0;
    a_n = gcd_a;
    b_n = gcd_b;
    valid_n = out_valid;
    y_n = out_y;
    err_n = out_error;
    to_n = out_timeout;
    case (state)
      IDLE: if (!empty) begin
        state_n = ISSUE;
        start_n = 1'b1;
        a_n = head[2*DATA_W-1:DATA_W];
        b_n = head[DATA_W-1:0];
      end
      ISSUE: begin
        state_n = WAIT;
        cnt_n = '0;
      end
      WAIT: if (gcd_done) begin
        state_n = HOLD;
        valid_n = 1'b1;
        y_n = gcd_y;
        err_n = gcd_error;
        to_n = 1'b0;
      end else if (cnt == TW'(TIMEOUT)) begin
        state_n = HOLD;
        valid_n = 1'b1;
        y_n = '0;
        err_n = 1'b1;
        to_n = 1'b1;
      end else cnt_n = cnt + 1'b1;
      HOLD: if (out_ready) begin
        state_n = IDLE;
        valid_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end
  // state, counter and all outputs are registered; in_ready is held low while in reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      in_ready <= 1'b0;
      gcd_start <= 1'b0;
      gcd_a <= '0;
      gcd_b <= '0;
      out_valid <= 1'b0;
      out_y <= '0;
      out_error <= 1'b0;
      out_timeout <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      in_ready <= ready_n;
      gcd_start <= start_n;
      gcd_a <= a_n;
      gcd_b <= b_n;
      out_valid <= valid_n;
      out_y <= y_n;
      out_error <= err_n;
      out_timeout <= to_n;
    end
endmodule
